// File: rtl/bank_timing_array.sv
// Per-bank DDR timing tracker array: one timing FSM per bank, a command
// decoder with legality checking, runtime timing registers, auto-precharge,
// all-bank PRA/REF and a refresh-interval tracker with postponed refresh count.
// Command interface: a command is present when cmd_valid=1 and is always
// consumed in that cycle (no back-pressure); rejection is signalled by a
// one-cycle cmd_illegal pulse on the following cycle.
module bank_timing_array #(
  parameter int BL      = 8,
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int TW      = 8,
  parameter int REFIW   = 16,
  parameter int MAXPEND = 8,
  parameter int D_RCD   = 17,
  parameter int D_RP    = 17,
  parameter int D_RAS   = 32,
  parameter int D_RFC   = 34,
  parameter int D_CL    = 17,
  parameter int D_CWL   = 10,
  parameter int D_WR    = 14,
  parameter int D_RTP   = 7,
  parameter int D_REFI  = 9360
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cfg_we,
  input  logic [3:0]                                  cfg_addr,
  input  logic [REFIW-1:0]                            cfg_wdata,
  input  logic                                        cmd_valid,
  input  logic [2:0]                                  cmd,
  input  logic [BGWIDTH-1:0]                          bg,
  input  logic [BAWIDTH-1:0]                          ba,
  output logic [3*(2**(BGWIDTH+BAWIDTH))-1:0]         bank_state,
  output logic [(2**(BGWIDTH+BAWIDTH))-1:0]           bank_open,
  output logic                                        cmd_illegal,
  output logic [3:0]                                  refresh_pending,
  output logic                                        refresh_due
);
  localparam int IW = BGWIDTH + BAWIDTH;
  localparam int NB = 2**IW;
  localparam logic [TW-1:0] HALF_BL = TW'(BL / 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ACTIVATING = 3'd1, S_ACTIVE = 3'd2, S_READING = 3'd3,
    S_WRITING = 3'd4, S_PRECHARGING = 3'd5, S_REFRESHING = 3'd6
  } state_t;

  localparam logic [2:0] C_ACT = 3'd0, C_RD = 3'd1, C_RDA = 3'd2, C_WR = 3'd3,
                         C_WRA = 3'd4, C_PR = 3'd5, C_PRA = 3'd6, C_REF = 3'd7;

  // Timing register file indices (cfg_addr 0..7); REFI lives in its own register.
  localparam int R_RCD = 0, R_RP = 1, R_RAS = 2, R_RFC = 3, R_CL = 4, R_CWL = 5, R_WR = 6;
  localparam logic [3:0] A_REFI = 4'd8;
  localparam logic [TW-1:0] TRESET [8] = '{TW'(D_RCD), TW'(D_RP), TW'(D_RAS), TW'(D_RFC),
                                           TW'(D_CL), TW'(D_CWL), TW'(D_WR), TW'(D_RTP)};

  logic [TW-1:0]    treg [8];
  logic [REFIW-1:0] t_refi;

  state_t        st_q [NB];
  state_t        st_d [NB];
  logic [TW-1:0] ctr_q [NB];
  logic [TW-1:0] ctr_d [NB];
  logic [TW-1:0] ras_q [NB];
  logic [TW-1:0] ras_d [NB];
  logic          ap_q [NB];
  logic          ap_d [NB];

  logic [IW-1:0]    tgt;
  logic             all_idle, pra_ok, legal, take, hit;
  logic [REFIW-1:0] refi_q, refi_last;
  logic [3:0]       pend_q;
  logic             wrap, ref_take;

  // A programmed 0 behaves as a 1-cycle interval.
  function automatic logic [TW-1:0] ld(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Timing registers: a write lands at the edge, so a same-cycle command sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) treg[i] <= TRESET[i];
      t_refi <= REFIW'(D_REFI);
    end else if (cfg_we) begin
      if (!cfg_addr[3]) treg[cfg_addr[2:0]] <= cfg_wdata[TW-1:0];
      else if (cfg_addr == A_REFI) t_refi <= cfg_wdata;
    end
  end

  // Command legality and per-bank next-state / counter logic.
  always_comb begin
    all_idle = 1'b1;
    pra_ok   = 1'b1;
    hit      = 1'b0;
    tgt      = {bg, ba};
    for (int i = 0; i < NB; i++) begin
      if (st_q[i] != S_IDLE) all_idle = 1'b0;
      if (!(st_q[i] == S_IDLE || (st_q[i] == S_ACTIVE && ras_q[i] == '0))) pra_ok = 1'b0;
    end
    case (cmd)
      C_ACT:                   legal = (st_q[tgt] == S_IDLE);
      C_RD, C_RDA, C_WR, C_WRA: legal = (st_q[tgt] == S_ACTIVE);
      C_PR:                    legal = (st_q[tgt] == S_IDLE) ||
                                       (st_q[tgt] == S_ACTIVE && ras_q[tgt] == '0);
      C_PRA:                   legal = pra_ok;
      default:                 legal = all_idle;
    endcase
    take = cmd_valid && legal;

    for (int i = 0; i < NB; i++) begin
      st_d[i]  = st_q[i];
      ctr_d[i] = ctr_q[i];
      ap_d[i]  = ap_q[i];
      ras_d[i] = (ras_q[i] != '0) ? ras_q[i] - TW'(1) : '0;
      hit      = (tgt == IW'(i));
      // Autonomous progress of the timed states.
      case (st_q[i])
        S_ACTIVATING: begin
          if (ctr_q[i] != '0) ctr_d[i] = ctr_q[i] - TW'(1);
          else                st_d[i]  = S_ACTIVE;
        end
        S_READING, S_WRITING: begin
          if (ctr_q[i] != '0) ctr_d[i] = ctr_q[i] - TW'(1);
          else if (!ap_q[i])  st_d[i]  = S_ACTIVE;
          else if (ras_q[i] == '0) begin
            // Auto-precharge waits in place until tRAS has elapsed.
            st_d[i]  = S_PRECHARGING;
            ctr_d[i] = ld(treg[R_RP]);
            ap_d[i]  = 1'b0;
          end
        end
        S_PRECHARGING, S_REFRESHING: begin
          if (ctr_q[i] != '0) ctr_d[i] = ctr_q[i] - TW'(1);
          else                st_d[i]  = S_IDLE;
        end
        default: ;
      endcase
      // Legal commands only touch IDLE/ACTIVE banks, which never move on their own.
      if (take) begin
        case (cmd)
          C_ACT: if (hit) begin
            st_d[i]  = S_ACTIVATING;
            ctr_d[i] = ld(treg[R_RCD]);
            ras_d[i] = ld(treg[R_RAS]);
          end
          C_RD, C_RDA: if (hit) begin
            st_d[i]  = S_READING;
            ctr_d[i] = treg[R_CL] + HALF_BL - TW'(1);
            ap_d[i]  = (cmd == C_RDA);
          end
          C_WR, C_WRA: if (hit) begin
            st_d[i]  = S_WRITING;
            ctr_d[i] = treg[R_CWL] + HALF_BL + treg[R_WR] - TW'(1);
            ap_d[i]  = (cmd == C_WRA);
          end
          C_PR, C_PRA: if ((hit || cmd == C_PRA) && st_q[i] == S_ACTIVE) begin
            st_d[i]  = S_PRECHARGING;
            ctr_d[i] = ld(treg[R_RP]);
          end
          default: begin
            st_d[i]  = S_REFRESHING;
            ctr_d[i] = ld(treg[R_RFC]);
          end
        endcase
      end
    end
  end

  // Bank state, counter and auto-precharge registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        st_q[i]  <= S_IDLE;
        ctr_q[i] <= '0;
        ras_q[i] <= '0;
        ap_q[i]  <= 1'b0;
      end
      cmd_illegal <= 1'b0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        st_q[i]  <= st_d[i];
        ctr_q[i] <= ctr_d[i];
        ras_q[i] <= ras_d[i];
        ap_q[i]  <= ap_d[i];
      end
      cmd_illegal <= cmd_valid && !legal;
    end
  end

  assign refi_last = (t_refi == '0) ? '0 : t_refi - REFIW'(1);
  assign wrap      = (refi_q >= refi_last);
  assign ref_take  = take && (cmd == C_REF);

  // Refresh interval counter and owed-refresh count; a wrap and a REF together cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refi_q <= '0;
      pend_q <= '0;
    end else begin
      if (cfg_we && cfg_addr == A_REFI) refi_q <= '0;
      else if (wrap)                    refi_q <= '0;
      else                              refi_q <= refi_q + REFIW'(1);
      if (wrap && !ref_take && pend_q != 4'(MAXPEND)) pend_q <= pend_q + 4'd1;
      else if (ref_take && !wrap && pend_q != 4'd0)   pend_q <= pend_q - 4'd1;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_out
    assign bank_state[3*g +: 3] = st_q[g];
    assign bank_open[g]         = (st_q[g] == S_ACTIVE);
  end

  assign refresh_pending = pend_q;
  assign refresh_due     = (pend_q != 4'd0);

endmodule

// File: tb/tb_bank_timing_array.sv
// Testbench for bank_timing_array: directed scenarios with fixed expectations
// plus randomized traffic checked against a timestamp-based reference model.
module tb_bank_timing_array;
  localparam int NB = 16;
  localparam int S_IDLE = 0, S_ACTIVATING = 1, S_ACTIVE = 2, S_READING = 3,
                 S_WRITING = 4, S_PRECHARGING = 5, S_REFRESHING = 6;
  localparam int C_ACT = 0, C_RD = 1, C_RDA = 2, C_WR = 3, C_WRA = 4,
                 C_PR = 5, C_PRA = 6, C_REF = 7;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = '0;
  logic [1:0]  bg = '0;
  logic [1:0]  ba = '0;
  logic [47:0] bank_state;
  logic [15:0] bank_open;
  logic        cmd_illegal;
  logic [3:0]  refresh_pending;
  logic        refresh_due;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank_timing_array dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cmd_valid(cmd_valid), .cmd(cmd), .bg(bg), .ba(ba),
    .bank_state(bank_state), .bank_open(bank_open), .cmd_illegal(cmd_illegal),
    .refresh_pending(refresh_pending), .refresh_due(refresh_due)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] bstate(input int i);
    return bank_state[3*i +: 3];
  endfunction

  // ---------------- reference model ----------------
  // Each bank is tracked as a state plus the absolute edge at which its timed
  // phase ends and the first edge at which tRAS is satisfied.
  int  m_st [NB];
  int  m_end [NB];
  int  m_ras [NB];
  bit  m_ap [NB];
  int  treg [8];
  int  t_refi, m_e, m_r, m_pend;
  bit  m_ill;
  logic [52:0] exp_q [$];

  function automatic int mx1(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_st[i] = S_IDLE; m_end[i] = 0; m_ras[i] = 0; m_ap[i] = 1'b0;
    end
    treg = '{17, 17, 32, 34, 17, 10, 14, 7};
    t_refi = 9360; m_e = 0; m_r = 0; m_pend = 0; m_ill = 1'b0;
  endtask

  task automatic model_step();
    int pre [NB];
    int sel, c;
    bit all_idle, pra_ok, legal, wrap, ref_ok;
    logic [47:0] st_v;
    m_e++;
    sel = int'({bg, ba});
    c = int'(cmd);
    all_idle = 1'b1; pra_ok = 1'b1;
    for (int i = 0; i < NB; i++) begin
      pre[i] = m_st[i];
      if (pre[i] != S_IDLE) all_idle = 1'b0;
      if (!(pre[i] == S_IDLE || (pre[i] == S_ACTIVE && m_e >= m_ras[i]))) pra_ok = 1'b0;
    end
    if (c == C_ACT) legal = (pre[sel] == S_IDLE);
    else if (c >= C_RD && c <= C_WRA) legal = (pre[sel] == S_ACTIVE);
    else if (c == C_PR) legal = (pre[sel] == S_IDLE) || (pre[sel] == S_ACTIVE && m_e >= m_ras[sel]);
    else if (c == C_PRA) legal = pra_ok;
    else legal = all_idle;
    legal = legal && cmd_valid;
    m_ill = cmd_valid && !legal;
    for (int i = 0; i < NB; i++) begin
      if (m_e > m_end[i]) begin
        if (pre[i] == S_ACTIVATING) m_st[i] = S_ACTIVE;
        else if (pre[i] == S_READING || pre[i] == S_WRITING) begin
          if (!m_ap[i]) m_st[i] = S_ACTIVE;
          else if (m_e >= m_ras[i]) begin
            m_st[i] = S_PRECHARGING; m_end[i] = m_e + mx1(treg[1]) - 1; m_ap[i] = 1'b0;
          end
        end else if (pre[i] == S_PRECHARGING || pre[i] == S_REFRESHING) m_st[i] = S_IDLE;
      end
    end
    if (legal) begin
      if (c == C_ACT) begin
        m_st[sel] = S_ACTIVATING; m_end[sel] = m_e + mx1(treg[0]) - 1; m_ras[sel] = m_e + mx1(treg[2]);
      end else if (c == C_RD || c == C_RDA) begin
        m_st[sel] = S_READING; m_end[sel] = m_e + treg[4] + 3; m_ap[sel] = (c == C_RDA);
      end else if (c == C_WR || c == C_WRA) begin
        m_st[sel] = S_WRITING; m_end[sel] = m_e + treg[5] + 4 + treg[6] - 1; m_ap[sel] = (c == C_WRA);
      end else if (c == C_PR || c == C_PRA) begin
        for (int i = 0; i < NB; i++)
          if ((i == sel || c == C_PRA) && pre[i] == S_ACTIVE) begin
            m_st[i] = S_PRECHARGING; m_end[i] = m_e + mx1(treg[1]) - 1;
          end
      end else begin
        for (int i = 0; i < NB; i++) begin
          m_st[i] = S_REFRESHING; m_end[i] = m_e + mx1(treg[3]) - 1;
        end
      end
    end
    wrap = ((m_e - m_r) % mx1(t_refi)) == 0;
    ref_ok = legal && c == C_REF;
    if (wrap && !ref_ok) m_pend = (m_pend < 8) ? m_pend + 1 : 8;
    else if (ref_ok && !wrap) m_pend = (m_pend > 0) ? m_pend - 1 : 0;
    if (cfg_we) begin
      if (cfg_addr < 8) treg[cfg_addr] = int'(cfg_wdata[7:0]);
      else if (cfg_addr == 8) begin t_refi = int'(cfg_wdata); m_r = m_e; end
    end
    for (int i = 0; i < NB; i++) st_v[3*i +: 3] = 3'(m_st[i]);
    exp_q.push_back({st_v, m_ill, 4'(m_pend)});
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
    end else model_step();
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [52:0] x;
    logic [15:0] eo;
    if (!rst && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      for (int i = 0; i < NB; i++) eo[i] = (x[5 + 3*i +: 3] == 3'(S_ACTIVE));
      check("sb_bank_state", bank_state, x[52:5]);
      check("sb_bank_open", bank_open, eo);
      check("sb_cmd_illegal", cmd_illegal, x[4]);
      check("sb_refresh_pending", refresh_pending, x[3:0]);
      check("sb_refresh_due", refresh_due, x[3:0] != 4'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int c, input int g, input int b,
                       input bit we, input int a, input int d);
    @(negedge clk);
    cmd_valid = v; cmd = 3'(c); bg = 2'(g); ba = 2'(b);
    cfg_we = we; cfg_addr = 4'(a); cfg_wdata = 16'(d);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) idle();
  endtask

  task automatic issue(input int c, input int g, input int b);
    drive(1'b1, c, g, b, 1'b0, 0, 0);
  endtask

  task automatic cfg(input int a, input int d);
    drive(1'b0, 0, 0, 0, 1'b1, a, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, w, a, c;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", bank_state, 0);
    check("reset_open", bank_open, 0);
    check("reset_illegal", cmd_illegal, 0);
    check("reset_pending", refresh_pending, 0);
    @(negedge clk);
    rst = 1'b0;

    // ACT bank 6: 17 cycles ACTIVATING, then ACTIVE
    issue(C_ACT, 1, 2);
    for (int k = 0; k < 17; k++) begin
      idle(); check("act_activating", bstate(6), S_ACTIVATING);
    end
    idle();
    check("act_active", bstate(6), S_ACTIVE);
    check("act_open", bank_open, 16'h0040);
    check("act_others_idle", bank_state & ~(48'h7 << 18), 0);
    // PR too early is rejected, later PR precharges for tRP
    idle();
    issue(C_PR, 1, 2);
    idle();
    check("pr_early_illegal", cmd_illegal, 1);
    check("pr_early_stays", bstate(6), S_ACTIVE);
    idle_n(18);
    issue(C_PR, 1, 2);
    for (int k = 0; k < 17; k++) begin
      idle(); check("pr_precharging", bstate(6), S_PRECHARGING);
      if (k == 0) check("pr_legal", cmd_illegal, 0);
    end
    idle(); check("pr_idle", bstate(6), S_IDLE);

    // RDA on bank 0 with default tRP, then with tRP=5
    for (int pass = 0; pass < 2; pass++) begin
      issue(C_ACT, 0, 0);
      idle_n(40);
      if (pass == 1) cfg(1, 5);
      issue(C_RDA, 0, 0);
      for (int k = 0; k < 21; k++) begin
        idle(); check("rda_reading", bstate(0), S_READING);
      end
      for (int k = 0; k < (pass == 0 ? 17 : 5); k++) begin
        idle(); check("rda_precharging", bstate(0), S_PRECHARGING);
      end
      idle(); check("rda_idle", bstate(0), S_IDLE);
    end

    // Refresh interval 20: one owed refresh per 20 cycles, saturating at 8
    cfg(8, 20);
    for (int i = 1; i <= 170; i++) begin
      idle();
      check("refi_pending", refresh_pending, ((i - 1) / 20 > 8) ? 8 : (i - 1) / 20);
      check("refi_due", refresh_due, i > 20);
    end

    // REF rejected with an open bank; PRA then REF refreshes everything
    cfg(8, 1000);
    issue(C_ACT, 1, 2);
    idle_n(40);
    issue(C_REF, 0, 0);
    idle();
    check("ref_illegal", cmd_illegal, 1);
    check("ref_no_change", bank_state, 48'h7 & 48'h0 | (48'd2 << 18));
    issue(C_PRA, 0, 0);
    idle_n(20);
    check("pra_all_idle", bank_state, 0);
    issue(C_REF, 0, 0);
    for (int k = 0; k < 34; k++) begin
      idle(); check("ref_refreshing", bank_state, {16{3'd6}});
      if (k == 0) check("ref_pending_dec", refresh_pending, 7);
    end
    idle(); check("ref_done_idle", bank_state, 0);

    // Asynchronous reset in the middle of a refresh
    issue(C_ACT, 2, 1);
    idle_n(3);
    issue(C_REF, 0, 0);
    idle_n(5);
    #2 rst = 1'b1;
    #1;
    check("arst_state", bank_state, 0);
    check("arst_pending", refresh_pending, 0);
    check("arst_illegal", cmd_illegal, 0);
    check("arst_open", bank_open, 0);
    @(negedge clk);
    rst = 1'b0;
    // tRP must be back to 17 after reset
    issue(C_ACT, 1, 1);
    idle_n(40);
    issue(C_PR, 1, 1);
    for (int k = 0; k < 17; k++) begin
      idle(); check("arst_trp_default", bstate(5), S_PRECHARGING);
    end
    idle(); check("arst_trp_idle", bstate(5), S_IDLE);

    // Randomized traffic against the model
    for (int it = 0; it < 2000; it++) begin
      r = $urandom_range(0, 99);
      if (it % 300 == 299) begin
        repeat (3) begin issue(C_PRA, 0, 0); idle_n(70); end
        issue(C_REF, 0, 0);
      end else if (r < 4) begin
        a = $urandom_range(0, 15);
        cfg(a, (a == 8) ? $urandom_range(20, 60) : $urandom_range(0, 40));
      end else if (r < 55) begin
        w = $urandom_range(0, 99);
        if (w < 30) c = C_ACT;
        else if (w < 60) c = $urandom_range(1, 4);
        else if (w < 80) c = C_PR;
        else if (w < 88) c = C_PRA;
        else c = C_REF;
        issue(c, $urandom_range(0, 3), $urandom_range(0, 3));
      end else idle();
    end
    idle_n(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_timing_array.md
Name: bank_timing_array

Overview:
- Parametrised successor to the per-bank DDR timing/state tracker.
- Holds one timing state machine per bank (BANKGROUPS x BANKSPERGROUP) and decodes an encoded command for the addressed bank.
- Adds runtime-writable timing registers, auto-precharge, all-bank commands (PRA, REF), command-legality checking and a refresh-interval tracker with postponed-refresh counting.
- Sits between the memory-controller command path and the bank storage models.

Parameters:
BL, 8, burst length; burst occupies BL/2 cycles
BGWIDTH, 2, bank-group address width; BANKGROUPS = 2**BGWIDTH
BAWIDTH, 2, bank address width; BANKSPERGROUP = 2**BAWIDTH; NB = BANKGROUPS*BANKSPERGROUP
TW, 8, timing register and per-bank counter width
REFIW, 16, tREFI register and counter width
MAXPEND, 8, saturation limit of postponed refreshes
D_RCD, D_RP, D_RAS, D_RFC, D_CL, D_CWL, D_WR, D_RTP, D_REFI: 17, 17, 32, 34, 17, 10, 14, 7, 9360; reset values of the timing registers

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  timing register write strobe
cfg_addr  in  4  register select: 0 RCD, 1 RP, 2 RAS, 3 RFC, 4 CL, 5 CWL, 6 WR, 7 RTP, 8 REFI; 9-15 ignored
cfg_wdata  in  REFIW  write data; low TW bits used except for REFI
cmd_valid  in  1  command present this cycle
cmd  in  3  0 ACT, 1 RD, 2 RDA, 3 WR, 4 WRA, 5 PR, 6 PRA, 7 REF
bg  in  BGWIDTH  target bank group
ba  in  BAWIDTH  target bank
bank_state  out  3*NB  per-bank state; bank index = bg*BANKSPERGROUP + ba
bank_open  out  NB  1 when bank is ACTIVE (accepts RD/WR/PR)
cmd_illegal  out  1  one-cycle pulse the cycle after a rejected command
refresh_pending  out  4  number of owed refreshes, 0..MAXPEND
refresh_due  out  1  refresh_pending != 0

Behaviour:
- State encoding: IDLE=0, ACTIVATING=1, ACTIVE=2, READING=3, WRITING=4, PRECHARGING=5, REFRESHING=6.
- Reset (asynchronous, active-high): all banks IDLE, all counters 0, autopre flags 0, timing registers = D_* values. Outputs after reset: cmd_illegal=0, refresh_pending=0, bank_open=0.
- All outputs are registered. A command sampled at edge N is visible at edge N+1.
- Every bank has a countdown ctr and a separate tRAS countdown rasctr. Load value is max(T,1)-1, so a programmed 0 behaves as 1 cycle. Counters saturate at 0.
- IDLE + ACT: -> ACTIVATING; ctr = tRCD-1, rasctr = tRAS-1.
- ACTIVATING: while ctr>0, decrement; at ctr==0 -> ACTIVE.
- ACTIVE + RD/RDA: -> READING; ctr = tCL + BL/2 - 1; autopre = (cmd==RDA).
- ACTIVE + WR/WRA: -> WRITING; ctr = tCWL + BL/2 + tWR - 1; autopre = (cmd==WRA).
- READING/WRITING end at ctr==0:
  - autopre=0 -> ACTIVE.
  - autopre=1 -> PRECHARGING with ctr = tRP-1, once rasctr==0; otherwise stay in the state until rasctr==0.
- ACTIVE + PR: legal only if rasctr==0; -> PRECHARGING, ctr = tRP-1.
- IDLE + PR: legal no-op.
- PRECHARGING: at ctr==0 -> IDLE.
- PRA (bg/ba ignored): legal only if every bank is IDLE, or ACTIVE with rasctr==0. ACTIVE banks -> PRECHARGING; IDLE banks unchanged.
- REF (bg/ba ignored): legal only if all banks are IDLE. All banks -> REFRESHING, ctr = tRFC-1, then -> IDLE at ctr==0.
- Any other (state, cmd) pair is illegal: no state change anywhere, cmd_illegal=1 on the next cycle.
- cmd_valid=0 means no command; cmd_illegal=0.
- Timing register writes take effect at the next edge. A command in the same cycle as a write uses the old value. Counters already running are never reloaded by a write.
- Refresh tracker:
  - REFIW counter counts 0..tREFI-1 and wraps.
  - Each wrap increments refresh_pending, saturating at MAXPEND.
  - A legal REF decrements refresh_pending, floored at 0.
  - Wrap and legal REF in the same cycle: net unchanged.
  - A write to the REFI register restarts the counter at 0.
- Reset asserted mid-operation aborts all counters and states immediately (asynchronous).

Test Plan:
- Reset, then cmd_valid ACT bg=1 ba=2 at cycle 0 -> bank_state[6] = ACTIVATING during cycles 1-17, ACTIVE at cycle 18; bank_open[6]=1 from cycle 18; all other banks remain IDLE.
- Bank 6 ACTIVE, PR at cycle 20 (rasctr still non-zero) -> cmd_illegal=1 at cycle 21, bank 6 stays ACTIVE. PR at cycle 40 -> PRECHARGING for 17 cycles, then IDLE.
- Bank 0 ACTIVE with tRAS elapsed, RDA -> READING for CL+4=21 cycles, then PRECHARGING for 17 cycles, then IDLE. Repeat with cfg write RP=5 issued before the RDA -> PRECHARGING lasts 5 cycles.
- cfg write REFI=20, no REF issued -> refresh_pending increments every 20 cycles and saturates at 8 after 160 cycles; refresh_due=1 from the first increment.
- With one bank ACTIVE, REF -> illegal pulse, no state changes. After PRA, then REF -> all NB banks REFRESHING for 34 cycles, then IDLE; refresh_pending decremented by 1.
- Assert rst while banks are ACTIVATING/REFRESHING -> same cycle: all banks IDLE, refresh_pending=0, timing registers back to D_* values.
